up_dn_cnt_seq_decoder: RTL and testbench

//  Receive-side companion to up_dn_cntr_with_load. Samples the counter's cnt bus and

---
 rtl/up_dn_cnt_seq_decoder.sv | 169 ++++++++++++++++
 tb/tb_up_dn_cnt_seq_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/up_dn_cnt_seq_decoder.sv
// Sequence decoder for an up/down counter's output bus.
// Classifies each sampled change as step up, step down, hold or jump,
// tracks count direction, and keeps saturating per-event statistics.
module up_dn_cnt_seq_decoder #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr,
  output logic             step_up,
  output logic             step_dn,
  output logic             hold,
  output logic             jump,
  output logic [WIDTH-1:0] jump_data,
  output logic             wrap,
  output logic             rev,
  output logic             dir_valid,
  output logic             dir_up,
  output logic [1:0]       state,
  output logic [CW-1:0]    up_steps,
  output logic [CW-1:0]    dn_steps,
  output logic [CW-1:0]    jumps
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_UNK   = 2'b01,
    S_UP    = 2'b10,
    S_DN    = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             prev_valid_q;
  logic [WIDTH-1:0] jump_data_q;
  logic             step_up_q, step_dn_q, hold_q, jump_q, wrap_q, rev_q;
  logic [CW-1:0]    up_steps_q, dn_steps_q, jumps_q;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_hold, is_jump;
  logic             qualified;

  // Classify the modular difference between the incoming and previous sample.
  always_comb begin
    delta     = cnt_in - prev_q;
    is_up     = (delta == WIDTH'(1));
    is_dn     = (delta == '1);
    is_hold   = (delta == '0);
    is_jump   = !(is_up || is_dn || is_hold);
    // An event exists only when a real sample meets a valid history; clr discards it.
    qualified = sample_en && !clr && prev_valid_q;
  end

  // Direction FSM, sample history, jump capture and registered event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      jump_data_q  <= '0;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      hold_q       <= 1'b0;
      jump_q       <= 1'b0;
      wrap_q       <= 1'b0;
      rev_q        <= 1'b0;
    end else begin
      // Pulses default low so each one lasts exactly a single cycle.
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      hold_q    <= 1'b0;
      jump_q    <= 1'b0;
      wrap_q    <= 1'b0;
      rev_q     <= 1'b0;
      if (clr) begin
        state_q      <= S_EMPTY;
        prev_q       <= '0;
        prev_valid_q <= 1'b0;
        jump_data_q  <= '0;
      end else if (sample_en) begin
        prev_q <= cnt_in;
        if (!prev_valid_q) begin
          // First sample only seeds the history; nothing to compare against yet.
          prev_valid_q <= 1'b1;
          state_q      <= S_UNK;
        end else begin
          step_up_q <= is_up;
          step_dn_q <= is_dn;
          hold_q    <= is_hold;
          jump_q    <= is_jump;
          wrap_q    <= (is_up && (prev_q == '1)) || (is_dn && (prev_q == '0));
          if (is_jump) begin
            jump_data_q <= cnt_in;
          end
          case (state_q)
            S_UNK: begin
              if (is_up) begin
                state_q <= S_UP;
              end else if (is_dn) begin
                state_q <= S_DN;
              end
            end
            S_UP: begin
              if (is_dn) begin
                state_q <= S_DN;
                rev_q   <= 1'b1;
              end else if (is_jump) begin
                state_q <= S_UNK;
              end
            end
            S_DN: begin
              if (is_up) begin
                state_q <= S_UP;
                rev_q   <= 1'b1;
              end else if (is_jump) begin
                state_q <= S_UNK;
              end
            end
            default: begin
              // History is valid, so direction is at best unknown.
              state_q <= S_UNK;
            end
          endcase
        end
      end
    end
  end

  // Saturating event statistics, updated on the same edge as the pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_steps_q <= '0;
      dn_steps_q <= '0;
      jumps_q    <= '0;
    end else if (clr) begin
      up_steps_q <= '0;
      dn_steps_q <= '0;
      jumps_q    <= '0;
    end else if (qualified) begin
      if (is_up && (up_steps_q != '1)) begin
        up_steps_q <= up_steps_q + 1'b1;
      end
      if (is_dn && (dn_steps_q != '1)) begin
        dn_steps_q <= dn_steps_q + 1'b1;
      end
      if (is_jump && (jumps_q != '1)) begin
        jumps_q <= jumps_q + 1'b1;
      end
    end
  end

  assign step_up   = step_up_q;
  assign step_dn   = step_dn_q;
  assign hold      = hold_q;
  assign jump      = jump_q;
  assign jump_data = jump_data_q;
  assign wrap      = wrap_q;
  assign rev       = rev_q;
  assign state     = state_q;
  assign dir_valid = (state_q == S_UP) || (state_q == S_DN);
  assign dir_up    = (state_q == S_UP);
  assign up_steps  = up_steps_q;
  assign dn_steps  = dn_steps_q;
  assign jumps     = jumps_q;

endmodule

// File: tb/tb_up_dn_cnt_seq_decoder.sv
// Scoreboard bench for up_dn_cnt_seq_decoder: directed scenarios plus
// randomized samples checked against an arithmetic reference model.
module tb_up_dn_cnt_seq_decoder;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MOD  = 2 ** W;
  localparam int CMAX = 2 ** CW - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_en = 1'b0;
  logic [W-1:0]  cnt_in = '0;
  logic          clr = 1'b0;
  logic          step_up, step_dn, hold, jump, wrap, rev, dir_valid, dir_up;
  logic [W-1:0]  jump_data;
  logic [1:0]    state;
  logic [CW-1:0] up_steps, dn_steps, jumps;

  up_dn_cnt_seq_decoder #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .cnt_in(cnt_in), .clr(clr),
    .step_up(step_up), .step_dn(step_dn), .hold(hold), .jump(jump),
    .jump_data(jump_data), .wrap(wrap), .rev(rev), .dir_valid(dir_valid),
    .dir_up(dir_up), .state(state), .up_steps(up_steps), .dn_steps(dn_steps),
    .jumps(jumps)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          su, sd, ho, ju;
    logic [W-1:0]  jd;
    logic          wr, rv;
    logic [1:0]    st;
    logic [CW-1:0] up, dn, jm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference model: direction as -1/0/+1, plain integer counters.
  bit m_have = 0;
  int m_dir  = 0;
  int m_prev = 0;
  int m_up = 0, m_dn = 0, m_jm = 0, m_jd = 0;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t x;
    x    = '0;
    x.st = !m_have ? 2'd0 : (m_dir == 0) ? 2'd1 : (m_dir > 0) ? 2'd2 : 2'd3;
    x.up = CW'(m_up);
    x.dn = CW'(m_dn);
    x.jm = CW'(m_jm);
    x.jd = W'(m_jd);
    return x;
  endfunction

  task automatic model_reset();
    m_have = 0; m_dir = 0; m_prev = 0;
    m_up = 0; m_dn = 0; m_jm = 0; m_jd = 0;
  endtask

  task automatic model_step(input bit c, input bit e, input int v, output exp_t x);
    bit su, sd, ho, ju, wr, rv;
    int d;
    su = 0; sd = 0; ho = 0; ju = 0; wr = 0; rv = 0;
    if (c) begin
      m_have = 0; m_dir = 0; m_up = 0; m_dn = 0; m_jm = 0; m_jd = 0;
    end else if (e) begin
      if (!m_have) begin
        m_have = 1;
        m_dir  = 0;
      end else begin
        d = (v - m_prev + MOD) % MOD;
        if (d == 1) begin
          su = 1; wr = (m_prev == MOD - 1); rv = (m_dir < 0);
          m_dir = 1; m_up = (m_up < CMAX) ? m_up + 1 : CMAX;
        end else if (d == MOD - 1) begin
          sd = 1; wr = (m_prev == 0); rv = (m_dir > 0);
          m_dir = -1; m_dn = (m_dn < CMAX) ? m_dn + 1 : CMAX;
        end else if (d == 0) begin
          ho = 1;
        end else begin
          ju = 1; m_jd = v; m_dir = 0;
          m_jm = (m_jm < CMAX) ? m_jm + 1 : CMAX;
        end
      end
      m_prev = v;
    end
    x    = snapshot();
    x.su = su; x.sd = sd; x.ho = ho; x.ju = ju; x.wr = wr; x.rv = rv;
  endtask

  task automatic check_all(input exp_t x);
    chk("step_up",   int'(step_up),   int'(x.su));
    chk("step_dn",   int'(step_dn),   int'(x.sd));
    chk("hold",      int'(hold),      int'(x.ho));
    chk("jump",      int'(jump),      int'(x.ju));
    chk("wrap",      int'(wrap),      int'(x.wr));
    chk("rev",       int'(rev),       int'(x.rv));
    chk("jump_data", int'(jump_data), int'(x.jd));
    chk("state",     int'(state),     int'(x.st));
    chk("dir_valid", int'(dir_valid), int'(x.st[1]));
    chk("dir_up",    int'(dir_up),    int'(x.st == 2'd2));
    chk("up_steps",  int'(up_steps),  int'(x.up));
    chk("dn_steps",  int'(dn_steps),  int'(x.dn));
    chk("jumps",     int'(jumps),     int'(x.jm));
  endtask

  // Drive one cycle of stimulus, queue the expected response, advance past the edge.
  task automatic cycle(input bit c, input bit e, input int v);
    exp_t x;
    clr = c; sample_en = e; cnt_in = W'(v);
    model_step(c, e, v, x);
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all(snapshot());
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: one expected record per driven cycle, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_all(x);
        n_txn++;
        $display("txn %0d: up=%0b dn=%0b hold=%0b jump=%0b jd=%0d wrap=%0b rev=%0b st=%0d cnts=%0d/%0d/%0d",
                 n_txn, step_up, step_dn, hold, jump, jump_data, wrap, rev, state,
                 up_steps, dn_steps, jumps);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, v;
    bit e, c;
    #3;
    do_reset();

    // Counting up from 5.
    cycle(0, 1, 5); cycle(0, 1, 6); cycle(0, 1, 7); cycle(0, 1, 8);
    // Wrap through all-ones.
    cycle(0, 1, 14); cycle(0, 1, 15); cycle(0, 1, 0); cycle(0, 1, 1);
    // Reversal to down.
    cycle(0, 1, 3); cycle(0, 1, 4); cycle(0, 1, 3); cycle(0, 1, 2);
    // Down-wrap through zero.
    cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 15);
    // Jump out of S_UP, then hold.
    cycle(0, 1, 3); cycle(0, 1, 4); cycle(0, 1, 9); cycle(0, 1, 9);
    // Idle gap between 6 and 7.
    cycle(0, 1, 6);
    for (int i = 0; i < 10; i++) cycle(0, 0, $urandom_range(0, MOD - 1));
    cycle(0, 1, 7);
    // Saturate the jump counter.
    for (int i = 0; i < 270; i++) cycle(0, 1, (i % 2) * 8);
    // Clear together with a sample: sample discarded.
    cycle(1, 1, 5);
    cycle(0, 1, 6);
    cycle(0, 1, 7);
    cycle(0, 0, 0);

    // Randomized traffic biased toward steps and holds.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      r = $urandom_range(0, 9);
      v = (r < 3) ? (m_prev + 1) % MOD :
          (r < 5) ? (m_prev + MOD - 1) % MOD :
          (r < 7) ? m_prev : $urandom_range(0, MOD - 1);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      cycle(c, e, v);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
